keypad_scanner: RTL and testbench

// 4x4 matrix keypad scanner/debouncer, downstream of freq_divider_keypad_module.

---
 rtl/keypad_scanner_pkg.sv | 13 +
 rtl/keypad_scanner_if.sv | 12 +
 rtl/keypad_scanner_col_sync.sv | 15 +
 rtl/keypad_scanner.sv | 99 +++++++++
 tb/tb_keypad_scanner.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_scanner_pkg.sv
// keypad_scanner_pkg: shared state encoding, constants and helpers for the 4x4 keypad scanner
package keypad_scanner_pkg;
   typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;
   localparam int KEY_CODE_W = 4;
   localparam logic [3:0] NO_KEY = 4'hF;
   localparam logic [3:0] ROW_IDLE = 4'b1110;
   function automatic logic [1:0] first_low(input logic [3:0] c);
      return !c[0] ? 2'd0 : !c[1] ? 2'd1 : !c[2] ? 2'd2 : 2'd3;
   endfunction
   function automatic logic [3:0] row_drive(input logic [1:0] r);
      return ~(4'b0001 << r);
   endfunction
endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: keypad matrix and key-report signals between scanner and its surroundings
interface keypad_scanner_if;
   import keypad_scanner_pkg::*;
   logic scan_tick;
   logic [3:0] col_n;
   logic [3:0] row_n;
   logic [KEY_CODE_W-1:0] key_code;
   logic key_valid;
   logic key_held;
   modport master(output scan_tick, col_n, input row_n, key_code, key_valid, key_held);
   modport slave(input scan_tick, col_n, output row_n, key_code, key_valid, key_held);
endinterface

// File: rtl/keypad_scanner_col_sync.sv
// keypad_scanner_col_sync: multi-stage synchroniser for the asynchronous active-low columns
module keypad_scanner_col_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] d,
   output logic [3:0] q
);
   logic [4*SYNC_STAGES-1:0] sh;
   always_ff @(posedge clk or posedge rst)
      if (rst) sh <= '1;
      else sh <= {sh[4*SYNC_STAGES-5:0], d};
   assign q = sh[4*SYNC_STAGES-1 -: 4];
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad row scanner and press/release debouncer paced by scan_tick
module keypad_scanner
   import keypad_scanner_pkg::*;
#(
   parameter int DEBOUNCE_TICKS = 4,
   parameter int SYNC_STAGES    = 2
) (
   input logic         clk,
   input logic         rst,
   keypad_scanner_if.slave kp
);
   localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_TICKS - 1);
   state_t state, state_nxt;
   logic tick_d, tick, lo, last, hit;
   logic [3:0] col_s;
   logic [1:0] row, row_nxt, lcol, lcol_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [KEY_CODE_W-1:0] code_nxt;
   logic valid_nxt, held_nxt;

   keypad_scanner_col_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk(clk), .rst(rst), .d(kp.col_n), .q(col_s)
   );

   assign tick = kp.scan_tick & ~tick_d;
   assign hit  = col_s != NO_KEY;
   assign lo   = ~col_s[lcol];
   assign last = cnt == LAST;

   always_ff @(posedge clk or posedge rst)
      if (rst) state <= SCAN;
      else state <= state_nxt;

   always_comb begin
      state_nxt = state;
      if (tick)
         case (state)
            SCAN:     state_nxt = hit ? DEBOUNCE : SCAN;
            DEBOUNCE: state_nxt = !lo ? SCAN : last ? HELD : DEBOUNCE;
            HELD:     state_nxt = lo ? HELD : RELEASE;
            RELEASE:  state_nxt = lo ? HELD : last ? SCAN : RELEASE;
            default:  state_nxt = SCAN;
         endcase
   end

   // cnt counts consecutive matching samples; it is cleared whenever a run ends
   always_comb begin
      cnt_nxt   = cnt;
      row_nxt   = row;
      lcol_nxt  = lcol;
      code_nxt  = kp.key_code;
      valid_nxt = 1'b0;
      held_nxt  = kp.key_held;
      if (tick)
         case (state)
            SCAN: begin
               lcol_nxt = hit ? first_low(col_s) : lcol;
               cnt_nxt  = hit ? CW'(1) : cnt;
               row_nxt  = hit ? row : row + 2'd1;
            end
            DEBOUNCE: begin
               cnt_nxt   = lo && !last ? cnt + 1'b1 : '0;
               row_nxt   = lo ? row : row + 2'd1;
               code_nxt  = lo && last ? {row, lcol} : kp.key_code;
               valid_nxt = lo && last;
               held_nxt  = lo && last;
            end
            HELD: cnt_nxt = lo ? cnt : CW'(1);
            RELEASE: begin
               cnt_nxt  = !lo && !last ? cnt + 1'b1 : '0;
               row_nxt  = !lo && last ? row + 2'd1 : row;
               held_nxt = lo || !last;
            end
            default: cnt_nxt = '0;
         endcase
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         tick_d       <= 1'b0;
         cnt          <= '0;
         row          <= 2'd0;
         lcol         <= 2'd0;
         kp.row_n     <= ROW_IDLE;
         kp.key_code  <= '0;
         kp.key_valid <= 1'b0;
         kp.key_held  <= 1'b0;
      end else begin
         tick_d       <= kp.scan_tick;
         cnt          <= cnt_nxt;
         row          <= row_nxt;
         lcol         <= lcol_nxt;
         kp.row_n     <= row_drive(row_nxt);
         kp.key_code  <= code_nxt;
         kp.key_valid <= valid_nxt;
         kp.key_held  <= held_nxt;
      end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: randomized and directed bench against a run-counting keypad model
module tb_keypad_scanner;
   localparam int DT = 4;
   localparam int SS = 2;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   keypad_scanner_if kp();
   keypad_scanner #(.DEBOUNCE_TICKS(DT), .SYNC_STAGES(SS)) dut (.clk(clk), .rst(rst), .kp(kp));

   int checks = 0, failures = 0, pulses = 0;
   logic [15:0] keys = '0;
   bit rst_drv = 1'b1;
   int mode = 0;
   logic st = 1'b0;
   int phase = 3;
   logic [3:0] scan_exp [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};

   // model: candidate column, run length of matching samples, accepted/held flag
   int m_row, m_cand, m_run, m_ticks = 0;
   bit m_held, m_valid, m_tick_d;
   logic [3:0] m_code;
   logic [3:0] h [SS];

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic int low_col(logic [3:0] c);
      for (int i = 0; i < 4; i++) if (!c[i]) return i;
      return -1;
   endfunction

   task automatic m_reset();
      m_row = 0; m_cand = -1; m_run = 0; m_held = 0; m_valid = 0; m_tick_d = 0; m_code = '0;
      for (int i = 0; i < SS; i++) h[i] = 4'hF;
   endtask

   task automatic m_step(logic t, logic [3:0] cn);
      logic [3:0] cs;
      bit tk;
      if (rst) begin m_reset(); return; end
      tk = t && !m_tick_d;
      m_tick_d = t;
      cs = h[SS-1];
      for (int i = SS - 1; i > 0; i--) h[i] = h[i-1];
      h[0] = cn;
      m_valid = 0;
      if (!tk) return;
      m_ticks++;
      if (m_held) begin
         if (cs[m_cand]) begin
            m_run++;
            if (m_run == DT) begin m_held = 0; m_cand = -1; m_run = 0; m_row = (m_row + 1) % 4; end
         end else m_run = 0;
      end else if (m_cand >= 0) begin
         if (!cs[m_cand]) begin
            m_run++;
            if (m_run == DT) begin m_code = 4'(m_row * 4 + m_cand); m_valid = 1; m_held = 1; m_run = 0; end
         end else begin m_cand = -1; m_run = 0; m_row = (m_row + 1) % 4; end
      end else if (cs != 4'hF) begin
         m_cand = low_col(cs); m_run = 1;
      end else m_row = (m_row + 1) % 4;
   endtask

   function automatic logic [3:0] cols();
      logic [3:0] c;
      for (int i = 0; i < 4; i++) c[i] = ~keys[m_row*4+i];
      return c;
   endfunction

   task automatic cycle();
      logic [3:0] rn;
      @(negedge clk);
      rn = ~(4'b0001 << m_row);
      chk("row_n", kp.row_n, rn);
      chk("key_code", kp.key_code, m_code);
      chk("key_valid", kp.key_valid, m_valid);
      chk("key_held", kp.key_held, m_held);
      if (kp.key_valid) pulses++;
      rst = rst_drv;
      if (mode == 1) st = 1'b0;
      else if (mode == 2) st = 1'b1;
      else begin
         phase--;
         if (phase <= 0) begin
            st = ~st;
            phase = st ? $urandom_range(1, 5) : $urandom_range(3, 6);
         end
      end
      kp.scan_tick = st;
      kp.col_n = cols();
      m_step(st, kp.col_n);
   endtask

   task automatic wait_ticks(int n);
      int t0 = m_ticks;
      int k = 0;
      while (m_ticks < t0 + n && k < n * 20 + 20) begin cycle(); k++; end
      if (m_ticks < t0 + n) chk("tick_timeout", m_ticks, t0 + n);
   endtask

   // which: 0 held, 1 released, 2 debouncing a candidate
   task automatic wait_for(int which);
      int k = 0;
      bit ok;
      do begin
         ok = which == 0 ? m_held : which == 1 ? !m_held : (m_cand >= 0 && !m_held);
         if (!ok) begin cycle(); k++; end
      end while (!ok && k < 600);
      if (!ok) chk("wait_timeout", k, which);
   endtask

   task automatic async_reset();
      #2 rst = 1'b1;
      rst_drv = 1'b1;
      mode = 1;
      #1;
      chk("areset_row_n", kp.row_n, 4'b1110);
      chk("areset_held", kp.key_held, 0);
      chk("areset_valid", kp.key_valid, 0);
      chk("areset_code", kp.key_code, 0);
      m_reset();
      pulses = 0;
      repeat (3) cycle();
      rst_drv = 1'b0;
      mode = 0;
      phase = 1;
   endtask

   initial begin
      int r;
      kp.scan_tick = 1'b0;
      kp.col_n = 4'hF;
      m_reset();
      #1 rst = 1'b1;
      #1;
      chk("reset_row_n", kp.row_n, 4'b1110);
      chk("reset_code", kp.key_code, 0);
      chk("reset_valid", kp.key_valid, 0);
      chk("reset_held", kp.key_held, 0);
      repeat (3) cycle();
      rst_drv = 1'b0;
      // idle scan order
      for (int i = 0; i < 4; i++) begin
         wait_ticks(1);
         cycle();
         chk("scan_row", kp.row_n, scan_exp[i]);
      end
      chk("idle_pulses", pulses, 0);
      // steady press row2 col1
      keys = 16'h1 << 9;
      wait_for(0);
      cycle();
      chk("press_code", kp.key_code, 4'h9);
      chk("press_held", kp.key_held, 1);
      chk("press_row", kp.row_n, 4'b1011);
      repeat (20) cycle();
      chk("press_pulses", pulses, 1);
      // bounce on row1 col3
      keys = '0;
      wait_for(1);
      pulses = 0;
      keys = 16'h1 << 7;
      wait_for(2);
      wait_ticks(1);
      keys = '0;
      wait_ticks(1);
      cycle();
      chk("bounce_pulses", pulses, 0);
      chk("bounce_code", kp.key_code, 4'h9);
      chk("bounce_row", kp.row_n, 4'b1011);
      // release glitch
      keys = 16'h1 << 9;
      wait_for(0);
      cycle();
      pulses = 0;
      keys = '0;
      wait_ticks(2);
      keys = 16'h1 << 9;
      wait_ticks(1);
      keys = '0;
      wait_ticks(3);
      cycle();
      chk("glitch_held", kp.key_held, 1);
      wait_ticks(1);
      cycle();
      chk("glitch_released", kp.key_held, 0);
      chk("glitch_pulses", pulses, 0);
      // two keys on row0, then a long scan_tick high
      keys = 16'h0005;
      wait_for(0);
      cycle();
      chk("dual_code", kp.key_code, 4'h0);
      keys = '0;
      wait_for(1);
      mode = 1;
      repeat (3) cycle();
      chk("pre_long_row", kp.row_n, 4'b1101);
      mode = 2;
      repeat (50) cycle();
      chk("long_tick_row", kp.row_n, 4'b1011);
      mode = 0;
      phase = 1;
      // reset during DEBOUNCE then during HELD
      keys = 16'h1 << 9;
      wait_for(2);
      async_reset();
      wait_for(0);
      cycle();
      chk("post_reset_press", pulses, 1);
      async_reset();
      keys = '0;
      wait_ticks(4);
      cycle();
      chk("post_reset_row", kp.row_n, 4'b1110);
      chk("post_reset_held", kp.key_held, 0);
      chk("post_reset_pulses", pulses, 0);
      // randomized key activity
      repeat (300) begin
         wait_ticks(1);
         r = $urandom_range(0, 9);
         if (r < 3) keys = '0;
         else if (r < 6) keys = 16'h1 << $urandom_range(0, 15);
         else if (r < 7) keys = keys | (16'h1 << $urandom_range(0, 15));
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
